// File: rtl/n_bit_bcd_converter_if.sv
// Valid/ready bundle between an arithmetic result source, the BCD converter and the display formatter.
// out_blank exists only when BCD_BLANK_EN is defined.
interface n_bit_bcd_converter_if #(
    parameter int N      = 32,
    parameter int DIGITS = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic [N-1:0]          in_data;
    logic                  in_signed;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_neg;
    logic [4*DIGITS-1:0]   out_bcd;
`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0]     out_blank;
`endif

    // Converter side
    modport slave (
        input  in_valid, in_data, in_signed, out_ready,
`ifdef BCD_BLANK_EN
        output out_blank,
`endif
        output in_ready, out_valid, out_neg, out_bcd
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_data, in_signed, out_ready,
`ifdef BCD_BLANK_EN
        input  out_blank,
`endif
        input  in_ready, out_valid, out_neg, out_bcd
    );
endinterface

// File: rtl/n_bit_bcd_converter.sv
// Iterative signed/unsigned binary-to-BCD converter (double-dabble, one bit per clock).
// Optional leading-zero blank mask enabled by defining BCD_BLANK_EN.
module n_bit_bcd_converter #(
    parameter int N      = 32,
    parameter int DIGITS = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    n_bit_bcd_converter_if.slave   bus
);
    localparam int CW = $clog2(N) + 1;

    // 10^DIGITS >= 2^N  <=>  DIGITS*log2(10) >= N
    if (real'(DIGITS) * 3.321928094887362 < real'(N)) begin : g_digits_chk
        $error("n_bit_bcd_converter: DIGITS too small for N");
    end

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    state_t state, state_nxt;

    logic [N-1:0]              sr;
    logic [N-1:0]              mag;
    logic [DIGITS-1:0][3:0]    acc;
    logic [DIGITS-1:0][3:0]    acc_adj;
    logic [4*DIGITS-1:0]       adj_flat;
    logic [4*DIGITS-1:0]       acc_nxt;
    logic                      neg;
    logic [CW-1:0]             cnt;
    logic                      last;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);

    assign mag  = (bus.in_signed && bus.in_data[N-1]) ? -bus.in_data : bus.in_data;
    assign last = (cnt == CW'(N-1));

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        assign acc_adj[g] = (acc[g] >= 4'd5) ? acc[g] + 4'd3 : acc[g];
    end

    assign adj_flat = acc_adj;
    assign acc_nxt  = {adj_flat[4*DIGITS-2:0], sr[N-1]};

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;
    logic              hi_zero;

    // Digit 0 is never blanked so a zero result still shows one "0".
    always_comb begin
        blank_nxt = '0;
        hi_zero   = 1'b1;
        for (int k = DIGITS-1; k >= 1; k--) begin
            hi_zero      = hi_zero && (acc_nxt[4*k +: 4] == 4'd0);
            blank_nxt[k] = hi_zero;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = CONV;
            CONV:    if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr          <= '0;
            acc         <= '0;
            cnt         <= '0;
            neg         <= 1'b0;
            bus.out_bcd <= '0;
            bus.out_neg <= 1'b0;
`ifdef BCD_BLANK_EN
            bus.out_blank <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    sr  <= mag;
                    neg <= bus.in_signed & bus.in_data[N-1];
                    acc <= '0;
                    cnt <= '0;
                end
                CONV: begin
                    sr  <= sr << 1;
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        bus.out_bcd <= acc_nxt;
                        bus.out_neg <= neg;
`ifdef BCD_BLANK_EN
                        bus.out_blank <= blank_nxt;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/n_bit_bcd_converter.md
# n_bit_bcd_converter

Sequential binary-to-BCD result stage that sits directly downstream of `n_bit_divider` and the other arithmetic units of the calculator. It accepts one N-bit result word, either signed or unsigned, through a valid/ready handshake. It converts the magnitude to packed BCD with an iterative shift-add-3 (double-dabble) loop, one bit per clock. It then presents a sign flag plus BCD digits to the display/formatter stage through a second valid/ready handshake.

## Interface
- `N`, 32, width of the binary result word.
- `DIGITS`, 10, number of BCD output digits. 10^DIGITS must exceed 2^N − 1. A smaller value is an elaboration `$error`.

- `clk` input 1: single clock, rising-edge.
- `rst` input 1: synchronous, active-high reset. It is sampled on the `clk` rising edge.
- `in_valid` input 1: upstream result is valid.
- `in_ready` output 1: block can accept a word. High only in IDLE.
- `in_data` input N: binary result, for example the divider quotient.
- `in_signed` input 1: 1 means `in_data` is two's complement; 0 means unsigned.
- `out_valid` output 1: BCD result is available. High only in DONE.
- `out_ready` input 1: downstream accepts the result.
- `out_neg` output 1: the result is negative.
- `out_bcd` output 4·DIGITS: packed BCD. Digit 0, the least significant, is in bits [3:0].
- `out_blank` output DIGITS: present only with `BCD_BLANK_EN`. See Configuration.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - CONV: N iterations.
  - DONE: `out_valid`=1.
- IDLE → CONV on `in_valid && in_ready`. On that edge:
  - Latch the magnitude into an N-bit shift register. The magnitude is `in_data`, or its two's complement when `in_signed && in_data[N-1]`.
  - Latch `neg = in_signed & in_data[N-1]`.
  - Clear the BCD accumulator and the iteration counter.
- Each CONV cycle does two things:
  - Every accumulator digit ≥ 5 gets +3.
  - The accumulator then shifts left one bit, taking in the shift register MSB, and the shift register shifts left.
  - Counter width is ⌈log2 N⌉+1.
- CONV → DONE on the edge that completes iteration N. `out_bcd` and `out_neg` load from the accumulator and `neg` on that same edge.
- DONE → IDLE on `out_valid && out_ready`.
- `in_data` = −2^(N−1) (signed) has magnitude 2^(N−1) as unsigned N-bit. It must convert correctly.
- Zero always gives `out_neg`=0.
- `out_bcd` and `out_neg` are stable throughout DONE. They hold their last value after the handshake until the next DONE load.
- Input changes while in CONV or DONE are ignored. There is no pipelining; one conversion is in flight at a time.

## Timing
- Reset: the state goes to IDLE.
  - `out_valid`=0, `out_neg`=0, `out_bcd`=0 (and `out_blank`=0).
  - `in_ready`=1 from the cycle after the reset edge.
- Reset asserted in any state, including mid-CONV or in DONE with a pending result, aborts the operation. The result is discarded and no `out_valid` is produced.
- Latency: `out_valid` rises exactly N rising edges after the accepting edge.
- Throughput is one word per N+2 cycles when `out_ready` is tied high: accept, N CONV, DONE/handshake.
- `in_ready` and `out_valid` are decoded directly from the state register. They have no combinational path from `in_valid` or `out_ready`.
- Backpressure: with `out_ready`=0 the block stays in DONE indefinitely, with `in_ready`=0.

## Configuration
- `BCD_BLANK_EN` defined: adds the registered output `out_blank[DIGITS-1:0]`.
  - Bit k=1 when digit k and all higher digits are zero.
  - Bit 0 is never set, so zero displays as a single "0".
  - It is loaded on the same edge as `out_bcd` and reset to 0.
- Not defined: no `out_blank` port and no blank logic. All other behaviour is identical.

## Test plan
- Unsigned max: `in_data`=32'hFFFFFFFF, `in_signed`=0 → after 32 edges, `out_bcd`=0x4294967295 (packed digits) and `out_neg`=0.
- Signed negative: 32'hFFFFFFF9, `in_signed`=1 → `out_neg`=1, `out_bcd`=0x0000000007. Also 32'h80000000 signed → `out_neg`=1, `out_bcd`=0x2147483648.
- Zero and blanking: 0 → `out_bcd`=0 and `out_neg`=0. With `BCD_BLANK_EN`, 123 → `out_blank`=10'b1111111000, and 0 → `out_blank`=10'b1111111110.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `out_valid`, `out_bcd` and `out_neg` stay constant, and `in_ready`=0 while `in_valid` is pulsed with a new word (the word is ignored). Raising `out_ready` → the block is back in IDLE on the next cycle.
- Reset mid-conversion: assert `rst` at CONV iteration 10 → the next cycle is IDLE, `out_valid` never rises, and outputs are 0. A following conversion of 9999 gives `out_bcd`=0x0000009999.
- Back-to-back: two words, 1 then 10, with `out_ready`=1 → the `out_valid` pulses are N+2 cycles apart, with results 0x0000000001 and 0x0000000010.
